multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; register count = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_READ, default 2, number of read ports, legal range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes and claims.
REQ-005 SHALL have port clock  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports we0 / we1  input  1  write enable, write ports 0 / 1.
REQ-008 SHALL have ports wa0 / wa1  input  ADDR_WIDTH  write index, ports 0 / 1.
REQ-009 SHALL have ports wd0 / wd1  input  DATA_WIDTH  write data, ports 0 / 1.
REQ-010 SHALL have port ra  input  NUM_READ*ADDR_WIDTH  read indices, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port rd  output  NUM_READ*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port rbusy  output  NUM_READ  bit k = scoreboard busy flag of register ra[k].
REQ-013 SHALL have port claim  input  1  mark register claim_addr as pending write.
REQ-014 SHALL have port claim_addr  input  ADDR_WIDTH  register index to claim.

Function
REQ-015 SHALL write wd0 to register wa0 at clock edge when we0=1, and likewise for port 1.
REQ-016 SHALL, when we0=we1=1 and wa0=wa1, store wd1 only (port 1 priority).
REQ-017 SHALL compute rd and rbusy combinationally, zero-cycle read latency.
REQ-018 SHALL bypass: when a read index matches an enabled write index in the same cycle, rd returns that write data (port 1 data if both match), not stored value.
REQ-019 SHALL, with ZERO_REG=1, return 0 on rd and 0 on rbusy for index 0 regardless of writes, bypass or claims; writes/claims to index 0 discarded.
REQ-020 SHALL, with ZERO_REG=0, treat register 0 as an ordinary register.
REQ-021 SHALL keep one busy bit per register; claim=1 sets busy[claim_addr] at the clock edge.
REQ-022 SHALL clear busy[wa0] / busy[wa1] at the clock edge on each enabled write.
REQ-023 SHALL, on claim and an enabled write to the same index in one cycle, leave busy set (claim wins; new producer in flight).
REQ-024 SHALL report rbusy[k] from registered busy state only; a same-cycle write clearing busy does not affect rbusy until next cycle, except rd bypass per REQ-018.
REQ-025 SHALL accept claim on an already-busy register without error; busy stays 1.
REQ-026 SHALL wrap no indices: every ADDR_WIDTH value is a valid register.

Reset
REQ-027 SHALL, on clock edge with reset=1, clear every register to 0 and every busy bit to 0.
REQ-028 SHALL give reset priority over same-cycle writes and claims; those are discarded.
REQ-029 SHALL drive rd=0 and rbusy=0 for all ports in the cycle after reset, absent bypassing writes.
REQ-030 SHALL initialise registers and busy bits to 0 at simulation start.

Verification
REQ-031 SHALL cover: reset, then we0=1 wa0=3 wd0=0xDEADBEEF; next cycle ra port0=3 -> rd port0=0xDEADBEEF.
REQ-032 SHALL cover: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> register 7 reads 0x22 next cycle; same-cycle rd of index 7 = 0x22.
REQ-033 SHALL cover: we1=1 wa1=9 wd1=0x55 with ra port1=9 same cycle -> rd port1=0x55 immediately (bypass).
REQ-034 SHALL cover: claim addr 5 -> rbusy=1 next cycle for ra=5; we0 wa0=5 -> rbusy=0 following cycle; claim+write addr 5 same cycle -> rbusy stays 1.
REQ-035 SHALL cover: ZERO_REG=1, we0 wa0=0 wd0=0xFFFFFFFF and claim addr 0 -> rd=0 and rbusy=0 for index 0.
REQ-036 SHALL cover: registers 1..4 written and 2 claimed, then reset together with we0 wa0=1 wd0=0x99 -> all rd=0, all rbusy=0 next cycle.

Source files
------------

// File: rtl/multiport_register_file.sv
// multiport_register_file: 2-write, NUM_READ-read register file with same-cycle write bypass
// and a per-register busy scoreboard set by claims and cleared by writes.
module multiport_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           we0,
   input  logic [ADDR_WIDTH-1:0]          wa0,
   input  logic [DATA_WIDTH-1:0]          wd0,
   input  logic                           we1,
   input  logic [ADDR_WIDTH-1:0]          wa1,
   input  logic [DATA_WIDTH-1:0]          wd1,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
   output logic [NUM_READ*DATA_WIDTH-1:0] rd,
   output logic [NUM_READ-1:0]            rbusy,
   input  logic                           claim,
   input  logic [ADDR_WIDTH-1:0]          claim_addr
);
   localparam int NREG = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] regs_q [NREG] = '{default: '0};
   logic [DATA_WIDTH-1:0] regs_d [NREG];
   logic [NREG-1:0]       busy_q = '0;
   logic [NREG-1:0]       busy_d;
   logic                  w0, w1, cl;
   // Index 0 traffic is dropped up front so the bypass and scoreboard never see it.
   assign w0 = we0 && !(ZERO_REG != 0 && wa0 == '0);
   assign w1 = we1 && !(ZERO_REG != 0 && wa1 == '0);
   assign cl = claim && !(ZERO_REG != 0 && claim_addr == '0);
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (w0) begin
         regs_d[wa0] = wd0;
         busy_d[wa0] = 1'b0;
      end
      if (w1) begin
         regs_d[wa1] = wd1;
         busy_d[wa1] = 1'b0;
      end
      if (cl) busy_d[claim_addr] = 1'b1;
      if (reset) begin
         regs_d = '{default: '0};
         busy_d = '0;
      end
   end
   always_ff @(posedge clock) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
   end
   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      logic                  z;
      assign a = ra[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign z = ZERO_REG != 0 && a == '0;
      assign rd[k*DATA_WIDTH +: DATA_WIDTH] = z ? '0 : (w1 && wa1 == a) ? wd1 :
                                              (w0 && wa0 == a) ? wd0 : regs_q[a];
      assign rbusy[k] = !z && busy_q[a];
   end
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: directed vectors with hand-computed expectations for
// writes, port-1 priority, bypass, scoreboard, zero register and reset.
module tb_multiport_register_file;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        we0 = 1'b0, we1 = 1'b0, claim = 1'b0;
   logic [4:0]  wa0 = '0, wa1 = '0, claim_addr = '0;
   logic [31:0] wd0 = '0, wd1 = '0;
   logic [9:0]  ra = '0;
   logic [63:0] rd;
   logic [1:0]  rbusy;
   int          n_checks = 0;
   int          n_fail = 0;

   multiport_register_file dut (
      .clock(clock), .reset(reset),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd), .rbusy(rbusy),
      .claim(claim), .claim_addr(claim_addr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0;
      we1 = 1'b0;
      claim = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      tick();
      idle();
      ra = {5'd9, 5'd3};
      #1;
      check("reset_rd0", rd[31:0], 32'h0);
      check("reset_rd1", rd[63:32], 32'h0);
      check("reset_rbusy", {30'b0, rbusy}, 32'h0);

      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
      #1;
      check("w0_bypass", rd[31:0], 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check("w0_stored", rd[31:0], 32'hDEADBEEF);

      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
      ra[4:0] = 5'd7;
      #1;
      check("prio_bypass", rd[31:0], 32'h22);
      tick();
      idle();
      #1;
      check("prio_stored", rd[31:0], 32'h22);

      we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55;
      ra = {5'd9, 5'd3};
      #1;
      check("w1_bypass", rd[63:32], 32'h55);
      check("other_port", rd[31:0], 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check("w1_stored", rd[63:32], 32'h55);

      claim = 1'b1; claim_addr = 5'd5;
      ra[4:0] = 5'd5;
      #1;
      check("claim_same_cycle", {31'b0, rbusy[0]}, 32'h0);
      tick();
      idle();
      #1;
      check("claim_busy", {31'b0, rbusy[0]}, 32'h1);
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h77;
      #1;
      check("clear_busy_same", {31'b0, rbusy[0]}, 32'h1);
      check("clear_bypass", rd[31:0], 32'h77);
      tick();
      idle();
      #1;
      check("clear_busy_next", {31'b0, rbusy[0]}, 32'h0);
      check("clear_stored", rd[31:0], 32'h77);
      claim = 1'b1; claim_addr = 5'd5;
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h88;
      tick();
      idle();
      #1;
      check("claim_wins", {31'b0, rbusy[0]}, 32'h1);
      check("claim_wins_data", rd[31:0], 32'h88);
      claim = 1'b1; claim_addr = 5'd5;
      tick();
      idle();
      #1;
      check("reclaim", {31'b0, rbusy[0]}, 32'h1);
      we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h66;
      tick();
      idle();
      #1;
      check("w1_clears", {31'b0, rbusy[0]}, 32'h0);
      check("w1_clears_data", rd[31:0], 32'h66);

      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h12345678;
      claim = 1'b1; claim_addr = 5'd0;
      ra = {5'd0, 5'd0};
      #1;
      check("zero_bypass0", rd[31:0], 32'h0);
      check("zero_bypass1", rd[63:32], 32'h0);
      tick();
      idle();
      #1;
      check("zero_rd", rd[31:0], 32'h0);
      check("zero_rbusy", {30'b0, rbusy}, 32'h0);

      for (int i = 1; i <= 4; i++) begin
         we0 = 1'b1; wa0 = 5'(i); wd0 = 32'h100 + i;
         claim = (i == 2); claim_addr = 5'd2;
         tick();
      end
      idle();
      ra = {5'd4, 5'd2};
      #1;
      check("pre_reset_rd2", rd[31:0], 32'h102);
      check("pre_reset_rd4", rd[63:32], 32'h104);
      check("pre_reset_busy2", {31'b0, rbusy[0]}, 32'h1);
      reset = 1'b1;
      we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h99;
      claim = 1'b1; claim_addr = 5'd3;
      tick();
      idle();
      for (int i = 1; i <= 9; i++) begin
         ra = {5'(i), 5'(i)};
         #1;
         check($sformatf("post_reset_rd_%0d", i), rd[31:0], 32'h0);
         check($sformatf("post_reset_busy_%0d", i), {30'b0, rbusy}, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
